// File: rtl/fp_sched_pkg.sv
// Shared types and helpers for the FP writeback scheduler.
// Register-file geometry and packed-bus slot extraction.
package fp_sched_pkg;

    localparam int FREG_CNT = 32;
    localparam int FREG_W   = 5;
    localparam int FLEN     = 64;
    localparam int MAX_REQ  = 8;

    function automatic logic [FREG_W-1:0] slot_frd(
        input logic [FREG_W*MAX_REQ-1:0] bus,
        input int unsigned               i
    );
        return bus[i*FREG_W +: FREG_W];
    endfunction

endpackage

// File: rtl/fp_writeback_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts at ptr and wraps.
// Produces a one-hot grant, its index and an any-grant flag.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any_grant
);

    // Walk offsets high to low so the nearest requester wins last.
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            automatic int j = (int'(ptr) + k) % N;
            if (req[j]) begin
                grant     = '0;
                grant[j]  = 1'b1;
                idx       = IW'(j);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_writeback_scheduler.sv
// FP register-file write-port scheduler with busy scoreboard.
// Arbitrates producers round-robin and stalls issue on RAW/WAW.
module fp_writeback_scheduler
    import fp_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int FLEN    = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_frs1,
    input  logic [4:0]              issue_frs2,
    input  logic [4:0]              issue_frd,
    output logic                    issue_stall,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [5*NUM_REQ-1:0]    req_frd,
    input  logic [FLEN*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    fwrite_en,
    output logic [4:0]              frd,
    output logic [FLEN-1:0]         fdata_in,
    output logic                    idle
);

    localparam int PW = $clog2(NUM_REQ);

    logic [FREG_CNT-1:0]       busy;
    logic [FREG_CNT-1:0]       busy_nxt;
    logic [PW-1:0]             rr_ptr;
    logic [NUM_REQ-1:0]        req_gated;
    logic [NUM_REQ-1:0]        grant;
    logic [PW-1:0]             g_idx;
    logic                      any_grant;
    logic                      accept;
    logic [FREG_W*MAX_REQ-1:0] frd_pad;
    logic [FREG_W-1:0]         g_frd;
    logic [FLEN-1:0]           g_data;

    assign req_gated = req_valid & {NUM_REQ{~reset}};

    rr_arbiter #(.N(NUM_REQ), .IW(PW)) u_arb (
        .req       (req_gated),
        .ptr       (rr_ptr),
        .grant     (grant),
        .idx       (g_idx),
        .any_grant (any_grant)
    );

    assign req_ready = grant;
    assign frd_pad   = (FREG_W*MAX_REQ)'(req_frd);
    assign g_frd     = slot_frd(frd_pad, 32'(g_idx));
    assign g_data    = req_data[32'(g_idx)*FLEN +: FLEN];

    assign issue_stall = ~reset & issue_valid
                       & (busy[issue_frs1] | busy[issue_frs2]
                       | busy[issue_frd]);
    assign accept      = issue_valid & ~issue_stall;
    assign idle        = ~|busy & ~fwrite_en;

    // Clear first so a same-cycle set on the same register wins.
    always_comb begin
        busy_nxt = busy;
        if (fwrite_en)
            busy_nxt[frd] = 1'b0;
        if (accept)
            busy_nxt[issue_frd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= '0;
            rr_ptr    <= '0;
            fwrite_en <= 1'b0;
            frd       <= '0;
            fdata_in  <= '0;
        end else begin
            busy <= busy_nxt;
            if (any_grant) begin
                if (32'(g_idx) == NUM_REQ - 1)
                    rr_ptr <= '0;
                else
                    rr_ptr <= g_idx + 1'b1;
                fwrite_en <= (g_frd != '0);
                frd       <= g_frd;
                fdata_in  <= g_data;
            end else begin
                fwrite_en <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fp_writeback_scheduler.md
# fp_writeback_scheduler

Sequences all writes into the 32×64-bit floating-point register file and keeps issue hazard-free. Up to NUM_REQ FP result producers (e.g. FADD pipe, FMUL pipe, iterative FDIV/FSQRT, FP load path) compete for the register file's single write port. A per-register busy scoreboard stalls FP issue on RAW/WAW hazards. The block sits between the FP execution units and the register file, and drives the register file's write-enable, destination-index and write-data inputs.

## Interface
Parameters:
- NUM_REQ, 4, number of writeback requesters (2..8)
- FLEN, 64, FP data width
- Reset/clock: reset, asynchronous, active-high; clock clk.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- issue_valid  in  1  FP instruction presented for issue
- issue_frs1  in  5  source register 1
- issue_frs2  in  5  source register 2
- issue_frd  in  5  destination register
- issue_stall  out  1  hazard; the instruction is not accepted this cycle
- req_valid  in  NUM_REQ  writeback request per producer
- req_frd  in  5*NUM_REQ  destination per producer; slot i occupies bits [5i+4:5i]
- req_data  in  FLEN*NUM_REQ  result per producer; slot i occupies bits [FLEN*i+FLEN-1:FLEN*i]
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- fwrite_en  out  1  register-file write enable (registered)
- frd  out  5  register-file write index (registered)
- fdata_in  out  FLEN  register-file write data (registered)
- idle  out  1  no busy bits set and fwrite_en low

## Operation
- **Scoreboard.** busy[31:0] holds one bit per FP register.
  - busy[0] is permanently 0. Register f0 is never written.
- **Issue stall.** issue_stall = issue_valid & (busy[issue_frs1] | busy[issue_frs2] | busy[issue_frd]). The stall is combinational from the registered busy vector.
- **Issue accept.** Accept = issue_valid & ~issue_stall. On accept, set busy[issue_frd] at the next edge, unless issue_frd == 0.
- **Arbitration.**
  - Round-robin with pointer rr_ptr (0..NUM_REQ-1). Search starts at rr_ptr and wraps.
  - At most one req_ready bit is high, and only for a requester whose req_valid is high.
  - After a grant to index g, rr_ptr becomes (g+1) mod NUM_REQ. With no grant, rr_ptr is unchanged.
  - req_ready is combinational from req_valid and rr_ptr. There is no other backpressure: one grant every cycle any request is valid.
- **Output register.**
  - On a granted transfer: fwrite_en <= (req_frd[g] != 0); frd <= req_frd[g]; fdata_in <= req_data[g].
  - With no grant: fwrite_en <= 0; frd and fdata_in hold their values.
- **Busy clear.** While fwrite_en is high, clear busy[frd] at the next edge. This is the same edge at which the register file captures the data.
- **Set/clear collision.** If a set and a clear hit the same register in the same cycle, the set wins. A WAW stall normally prevents this.
- **f0 writes.** A request with req_frd == 0 is granted and consumed normally. It produces no write and no busy change.
- **Producer contract.** Producers only request registers that are busy. A request for a non-busy register is written normally, and the clear is a no-op.

## Timing
- **Reset values.** While reset is high, all of the following hold, including when reset asserts mid-operation:
  - busy = 0, rr_ptr = 0
  - fwrite_en = 0, frd = 0, fdata_in = 0
  - req_ready = 0, issue_stall = 0, idle = 1
- **Reset release.** In-flight requests are dropped. Producers are flushed by the same reset.
- **Write latency.** A request granted at edge N gives fwrite_en = 1 during cycle N..N+1. The register file writes, and busy clears, at edge N+1.
- **Dependent issue.** A dependent instruction stalls through cycle N..N+1 and is unstalled in the cycle after edge N+1.
- **Dead cycles.** None between back-to-back grants. Throughput is one write per cycle.
- **Issue-to-busy.** An accepted issue sets busy at the next edge. A second instruction reading that register in the following cycle sees the stall.

## Structure
- **Shared package fp_sched_pkg:**
  - FREG_CNT = 32, FREG_W = 5, FLEN = 64
  - a function extracting slot i from the packed req_frd / req_data buses
- **Sub-module rr_arbiter** (parameter N): inputs req[N] and ptr; outputs one-hot grant[N], grant index and any_grant. It is reused for the later integer/FP load-port sharing.

## Test plan
- **Reset and idle.** Assert reset mid-stream with busy = 0x0000_00F0 and fwrite_en = 1.
  - Required: all outputs take their reset values immediately, and idle = 1 after release.
- **RAW stall.**
  - Issue frd = 5 → busy[5] = 1.
  - Next cycle, issue frs1 = 5 → issue_stall = 1.
  - req0 writes f5 = 0x4009_21FB_5444_2D18 at edge N → fwrite_en = 1, frd = 5 in cycle N..N+1; stall drops after edge N+1.
- **Round-robin.** req_valid = 4'b1111 held for 4 cycles from reset.
  - Required: grants are 0, 1, 2, 3 in order, fwrite_en stays high continuously, and rr_ptr wraps to 0.
- **f0 discard.** req2 with frd = 0 and data 0xDEAD.
  - Required: req_ready[2] = 1, fwrite_en = 0 next cycle, busy unchanged.
- **WAW and collision.**
  - Issue frd = 9 while busy[9] = 1 → issue_stall = 1.
  - Issue frd = 9 in the same cycle that fwrite_en = 1 with frd = 9 → stalled. The next attempt is accepted, leaving busy[9] = 1.
- **Partial contention.** req_valid = 4'b1010 with rr_ptr = 2.
  - Required: grant 3 first, then 1, then 3.
